// File: rtl/puf_soc_pkg.sv
// Shared types and helpers for the PUF SoC controller.
//   fsm_state_e : 3-bit controller state encoding (7 is illegal)
//   sel_width() : RO mux select width for a given mux length
package puf_soc_pkg;

  typedef enum logic [2:0] {
    ST_RESET      = 3'd0,
    ST_WAIT       = 3'd1,
    ST_RECEIVE    = 3'd2,
    ST_RO_DECODER = 3'd3,
    ST_EXECUTE    = 3'd4,
    ST_TRANSMIT   = 3'd5,
    ST_DUMP       = 3'd6
  } fsm_state_e;

  function automatic int sel_width(input int mux_length);
    return $clog2(mux_length);
  endfunction

endpackage

// File: rtl/puf_ro_decoder.sv
// Challenge register and field slicer.
//   clk, rst_n    : clock, synchronous active-low reset
//   i_capture     : latch i_chal into the challenge register
//   i_chal        : received challenge word
//   i_load        : load decoded fields from the held challenge
//   o_sel_mux_0/1 : RO mux selects (low two SW-wide fields)
//   o_max_count   : counter terminal value (remaining upper bits)
module puf_ro_decoder
  import puf_soc_pkg::*;
#(
  parameter int MUX_LENGTH   = 16,
  parameter int REG_BIT_SIZE = 40,
  localparam int SW          = sel_width(MUX_LENGTH),
  localparam int MW          = 8 * SW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_capture,
  input  logic [REG_BIT_SIZE-1:0] i_chal,
  input  logic                    i_load,
  output logic [SW-1:0]           o_sel_mux_0,
  output logic [SW-1:0]           o_sel_mux_1,
  output logic [MW-1:0]           o_max_count
);

  logic [REG_BIT_SIZE-1:0] r_chal;
  logic [SW-1:0]           r_sel_mux_0;
  logic [SW-1:0]           r_sel_mux_1;
  logic [MW-1:0]           r_max_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_chal      <= '0;
      r_sel_mux_0 <= '0;
      r_sel_mux_1 <= '0;
      r_max_count <= '0;
    end else begin
      if (i_capture) r_chal <= i_chal;
      // Fields only change on a decode, so they survive a return to RESET.
      if (i_load) begin
        r_sel_mux_0 <= r_chal[0 +: SW];
        r_sel_mux_1 <= r_chal[SW +: SW];
        r_max_count <= r_chal[2*SW +: MW];
      end
    end
  end

  assign o_sel_mux_0 = r_sel_mux_0;
  assign o_sel_mux_1 = r_sel_mux_1;
  assign o_max_count = r_max_count;

endmodule

// File: rtl/puf_soc_cntrlr.sv
// Top-level PUF SoC control FSM: RESET -> WAIT -> RECEIVE -> RO_DECODER
// (2 cycles) -> EXECUTE -> TRANSMIT or DUMP -> RESET.
//   clk, rst_n     : clock, synchronous active-low reset
//   i_start        : level, permits leaving RESET
//   i_op_mode      : debug request, sampled in EXECUTE (beats i_exec_done)
//   i_rx_*         : receiver ready / valid / done / challenge word
//   i_exec_done    : execution unit finished
//   i_tx_done      : transmit or dump finished
//   o_fsm_state    : state register
//   o_dcod_*       : decode capture cycle / fields-valid pulse
//   o_exec/tx/dump_enable : Moore state decodes
//   o_sel_mux_0/1, o_max_count : decoded challenge fields
module puf_soc_cntrlr
  import puf_soc_pkg::*;
#(
  parameter int MUX_LENGTH   = 16,
  parameter int REG_BIT_SIZE = 40,
  localparam int SW          = sel_width(MUX_LENGTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic                    i_op_mode,
  input  logic                    i_rx_ready,
  input  logic                    i_rx_valid,
  input  logic                    i_rx_done,
  input  logic [REG_BIT_SIZE-1:0] i_rx_data,
  input  logic                    i_exec_done,
  input  logic                    i_tx_done,
  output logic [2:0]              o_fsm_state,
  output logic                    o_dcod_ready,
  output logic                    o_dcod_enable,
  output logic                    o_exec_enable,
  output logic                    o_tx_enable,
  output logic                    o_dump_enable,
  output logic [SW-1:0]           o_sel_mux_0,
  output logic [SW-1:0]           o_sel_mux_1,
  output logic [8*SW-1:0]         o_max_count
);

  fsm_state_e r_state, w_next;
  // Second-cycle marker inside RO_DECODER.
  logic       r_dcod_phase;
  logic       w_capture;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_RESET;
      r_dcod_phase <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_dcod_phase <= (r_state == ST_RO_DECODER) && !r_dcod_phase;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      ST_RESET:      if (i_start) w_next = ST_WAIT;
      ST_WAIT:       if (i_rx_ready) w_next = ST_RECEIVE;
      ST_RECEIVE: begin
        if (i_rx_valid && i_rx_done) begin
          w_capture = 1'b1;
          w_next    = ST_RO_DECODER;
        end
      end
      ST_RO_DECODER: if (r_dcod_phase) w_next = ST_EXECUTE;
      ST_EXECUTE: begin
        if (i_op_mode)        w_next = ST_DUMP;
        else if (i_exec_done) w_next = ST_TRANSMIT;
      end
      ST_TRANSMIT:   if (i_tx_done) w_next = ST_RESET;
      ST_DUMP:       if (i_tx_done) w_next = ST_RESET;
      default:       w_next = ST_RESET;
    endcase
  end

  assign o_fsm_state   = r_state;
  assign o_dcod_enable = (r_state == ST_RO_DECODER) && !r_dcod_phase;
  assign o_dcod_ready  = (r_state == ST_RO_DECODER) &&  r_dcod_phase;
  assign o_exec_enable = (r_state == ST_EXECUTE);
  assign o_tx_enable   = (r_state == ST_TRANSMIT);
  assign o_dump_enable = (r_state == ST_DUMP);

  puf_ro_decoder #(
    .MUX_LENGTH  (MUX_LENGTH),
    .REG_BIT_SIZE(REG_BIT_SIZE)
  ) u_dec (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_capture  (w_capture),
    .i_chal     (i_rx_data),
    .i_load     (o_dcod_enable),
    .o_sel_mux_0(o_sel_mux_0),
    .o_sel_mux_1(o_sel_mux_1),
    .o_max_count(o_max_count)
  );

endmodule

// File: tb/tb_puf_soc_cntrlr.sv
module tb_puf_soc_cntrlr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start, i_op_mode, i_rx_ready, i_rx_valid, i_rx_done;
  logic [39:0] i_rx_data;
  logic        i_exec_done, i_tx_done;
  logic [2:0]  o_fsm_state;
  logic        o_dcod_ready, o_dcod_enable, o_exec_enable, o_tx_enable, o_dump_enable;
  logic [3:0]  o_sel_mux_0, o_sel_mux_1;
  logic [31:0] o_max_count;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  puf_soc_cntrlr #(.MUX_LENGTH(16), .REG_BIT_SIZE(40)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_op_mode    (i_op_mode),
    .i_rx_ready   (i_rx_ready),
    .i_rx_valid   (i_rx_valid),
    .i_rx_done    (i_rx_done),
    .i_rx_data    (i_rx_data),
    .i_exec_done  (i_exec_done),
    .i_tx_done    (i_tx_done),
    .o_fsm_state  (o_fsm_state),
    .o_dcod_ready (o_dcod_ready),
    .o_dcod_enable(o_dcod_enable),
    .o_exec_enable(o_exec_enable),
    .o_tx_enable  (o_tx_enable),
    .o_dump_enable(o_dump_enable),
    .o_sel_mux_0  (o_sel_mux_0),
    .o_sel_mux_1  (o_sel_mux_1),
    .o_max_count  (o_max_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs driven and outputs sampled 1 time unit after it.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_outs(input string tag, input logic [2:0] st, input logic [4:0] en);
    // en = {dcod_enable, dcod_ready, exec, tx, dump}
    chk({tag, ".state"}, 32'(o_fsm_state), 32'(st));
    chk({tag, ".en"}, 32'({o_dcod_enable, o_dcod_ready, o_exec_enable, o_tx_enable, o_dump_enable}),
        32'(en));
  endtask

  task automatic chk_fields(input string tag, input logic [3:0] s0, input logic [3:0] s1,
                            input logic [31:0] mx);
    chk({tag, ".sel0"}, 32'(o_sel_mux_0), 32'(s0));
    chk({tag, ".sel1"}, 32'(o_sel_mux_1), 32'(s1));
    chk({tag, ".max"}, o_max_count, mx);
  endtask

  // From RESET, walk through WAIT/RECEIVE/RO_DECODER into EXECUTE.
  task automatic run_to_exec(input string tag, input logic [39:0] data, input logic hold_start,
                             input logic [3:0] s0, input logic [3:0] s1, input logic [31:0] mx);
    i_start = 1'b1;
    tick();
    chk_outs({tag, ".wait"}, 3'd1, 5'b00000);
    i_start = hold_start;
    i_rx_ready = 1'b1;
    tick();
    chk_outs({tag, ".recv"}, 3'd2, 5'b00000);
    i_rx_ready = 1'b0;
    i_rx_valid = 1'b1;
    tick();
    chk_outs({tag, ".recv_hold"}, 3'd2, 5'b00000);
    i_rx_done = 1'b1;
    i_rx_data = data;
    tick();
    chk_outs({tag, ".dec1"}, 3'd3, 5'b10000);
    i_rx_valid = 1'b0;
    i_rx_done  = 1'b0;
    i_rx_data  = '0;
    tick();
    chk_outs({tag, ".dec2"}, 3'd3, 5'b01000);
    chk_fields({tag, ".dec2"}, s0, s1, mx);
    tick();
    chk_outs({tag, ".exec"}, 3'd4, 5'b00100);
  endtask

  initial begin
    rst_n = 1'b0;
    {i_start, i_op_mode, i_rx_ready, i_rx_valid, i_rx_done, i_exec_done, i_tx_done} = '0;
    i_rx_data = '0;

    // Reset
    tick(5);
    chk_outs("rst", 3'd0, 5'b00000);
    chk_fields("rst", 4'h0, 4'h0, 32'd0);
    rst_n = 1'b1;
    tick(2);
    chk_outs("rst_idle", 3'd0, 5'b00000);

    // Normal flow
    run_to_exec("norm", {32'd1024, 8'hA5}, 1'b0, 4'h5, 4'hA, 32'd1024);
    tick();
    chk_outs("norm.exec_hold", 3'd4, 5'b00100);
    i_exec_done = 1'b1;
    tick();
    chk_outs("norm.tx", 3'd5, 5'b00010);
    i_exec_done = 1'b0;
    tick();
    chk_outs("norm.tx_hold", 3'd5, 5'b00010);
    i_tx_done = 1'b1;
    tick();
    chk_outs("norm.back", 3'd0, 5'b00000);
    chk_fields("norm.keep", 4'h5, 4'hA, 32'd1024);
    i_tx_done = 1'b0;
    tick();
    chk_outs("norm.idle", 3'd0, 5'b00000);

    // Debug flow, with i_exec_done ignored in DUMP
    run_to_exec("dbg", {32'h0000_0123, 8'h3C}, 1'b0, 4'hC, 4'h3, 32'h123);
    i_op_mode = 1'b1;
    tick();
    chk_outs("dbg.dump", 3'd6, 5'b00001);
    i_op_mode   = 1'b0;
    i_exec_done = 1'b1;
    tick();
    chk_outs("dbg.ign_exec", 3'd6, 5'b00001);
    i_exec_done = 1'b0;
    i_tx_done   = 1'b1;
    tick();
    chk_outs("dbg.back", 3'd0, 5'b00000);
    i_tx_done = 1'b0;

    // Priority: op_mode beats exec_done
    run_to_exec("prio", {32'hDEAD_BEEF, 8'h70}, 1'b0, 4'h0, 4'h7, 32'hDEAD_BEEF);
    i_op_mode   = 1'b1;
    i_exec_done = 1'b1;
    tick();
    chk_outs("prio.dump", 3'd6, 5'b00001);
    i_op_mode   = 1'b0;
    i_exec_done = 1'b0;
    i_tx_done   = 1'b1;
    tick();
    chk_outs("prio.back", 3'd0, 5'b00000);
    i_tx_done = 1'b0;

    // Back-to-back with i_start held high
    run_to_exec("b2b", {32'h0000_00FF, 8'h12}, 1'b1, 4'h2, 4'h1, 32'hFF);
    i_exec_done = 1'b1;
    tick();
    chk_outs("b2b.tx", 3'd5, 5'b00010);
    i_exec_done = 1'b0;
    i_tx_done   = 1'b1;
    tick();
    chk_outs("b2b.reset", 3'd0, 5'b00000);
    i_tx_done = 1'b0;
    tick();
    chk_outs("b2b.wait", 3'd1, 5'b00000);
    chk_fields("b2b.keep", 4'h2, 4'h1, 32'hFF);
    i_start    = 1'b0;
    i_rx_ready = 1'b1;
    tick();
    chk_outs("b2b.recv", 3'd2, 5'b00000);
    i_rx_ready = 1'b0;
    i_rx_valid = 1'b1;
    i_rx_done  = 1'b1;
    i_rx_data  = {32'h0000_0042, 8'h9E};
    tick();
    chk_fields("b2b.old_in_dec1", 4'h2, 4'h1, 32'hFF);
    i_rx_valid = 1'b0;
    i_rx_done  = 1'b0;
    tick();
    chk_fields("b2b.new", 4'hE, 4'h9, 32'h42);
    tick();
    chk_outs("b2b.exec", 3'd4, 5'b00100);

    // Mid-operation reset from EXECUTE
    rst_n = 1'b0;
    tick();
    chk_outs("midrst", 3'd0, 5'b00000);
    chk_fields("midrst", 4'h0, 4'h0, 32'd0);
    rst_n = 1'b1;
    tick();
    chk_outs("midrst.idle", 3'd0, 5'b00000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
